// File: rtl/accel_cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module   : accel_cmd_queue
//  Purpose  : CPU-facing command/result queue for a math accelerator.
//             The CPU loads operands A/B into staging registers, then pushes
//             {A, B, opcode} into a command FIFO. A small sequencer offers one
//             command at a time to the math stage and captures its result
//             into a result FIFO, which the CPU reads back and pops.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             address/data_write/data_in/data_out - CPU register port
//             op_a/op_b/op_code/op_valid/op_ready  - command to math stage
//             res_valid/res_data                   - result from math stage
//  Revision : 1.0 - initial release
// ============================================================================
module accel_cmd_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  address,
  input  logic        data_write,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic [7:0]  op_a,
  output logic [7:0]  op_b,
  output logic [3:0]  op_code,
  output logic        op_valid,
  input  logic        op_ready,
  input  logic        res_valid,
  input  logic [15:0] res_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [7:0]       r_stage_a;
  logic [7:0]       r_stage_b;
  logic             r_overflow;

  logic [19:0]      r_cmd_mem [DEPTH];
  logic [PTR_W-1:0] r_cmd_wr_ptr;
  logic [PTR_W-1:0] r_cmd_rd_ptr;
  logic [CNT_W-1:0] r_cmd_count;

  logic [15:0]      r_res_mem [DEPTH];
  logic [PTR_W-1:0] r_res_wr_ptr;
  logic [PTR_W-1:0] r_res_rd_ptr;
  logic [CNT_W-1:0] r_res_count;

  // CPU write decode
  logic w_wr_a, w_wr_b, w_wr_push, w_wr_rpop, w_wr_clr;
  assign w_wr_a    = data_write && (address == 4'h0);
  assign w_wr_b    = data_write && (address == 4'h1);
  assign w_wr_push = data_write && (address == 4'h4);
  assign w_wr_rpop = data_write && (address == 4'h7);
  assign w_wr_clr  = data_write && (address == 4'h8) && data_in[6];

  logic w_cmd_full, w_cmd_empty, w_res_full, w_res_empty;
  assign w_cmd_full  = (r_cmd_count == C_DEPTH);
  assign w_cmd_empty = (r_cmd_count == '0);
  assign w_res_full  = (r_res_count == C_DEPTH);
  assign w_res_empty = (r_res_count == '0);

  // The sequencer only enters ISSUE with a non-empty command FIFO and nothing
  // else pops it, so the handshake alone qualifies the pop.
  logic w_cmd_pop, w_cmd_push, w_ovf_set;
  assign w_cmd_pop  = (r_state == ISSUE) && op_ready;
  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign w_cmd_push = w_wr_push && (!w_cmd_full || w_cmd_pop);
  assign w_ovf_set  = w_wr_push && w_cmd_full && !w_cmd_pop;

  logic w_res_pop, w_res_push;
  assign w_res_pop  = w_wr_rpop && !w_res_empty;
  // Issue is gated on free result space and only one command is in flight,
  // so the full guard is a safety net rather than a normal path.
  assign w_res_push = (r_state == WAIT) && res_valid && (!w_res_full || w_res_pop);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    op_valid     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_cmd_empty && (r_res_count < C_DEPTH)) begin
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        op_valid = 1'b1;
        if (op_ready) begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (res_valid) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage_a    <= '0;
      r_stage_b    <= '0;
      r_overflow   <= 1'b0;
      r_cmd_wr_ptr <= '0;
      r_cmd_rd_ptr <= '0;
      r_cmd_count  <= '0;
      r_res_wr_ptr <= '0;
      r_res_rd_ptr <= '0;
      r_res_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_cmd_mem[i] <= '0;
        r_res_mem[i] <= '0;
      end
    end else begin
      if (w_wr_a) begin
        r_stage_a <= data_in;
      end
      if (w_wr_b) begin
        r_stage_b <= data_in;
      end

      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (w_wr_clr) begin
        r_overflow <= 1'b0;
      end

      if (w_cmd_push) begin
        r_cmd_mem[r_cmd_wr_ptr] <= {r_stage_a, r_stage_b, data_in[3:0]};
        r_cmd_wr_ptr            <= r_cmd_wr_ptr + 1'b1;
      end
      if (w_cmd_pop) begin
        r_cmd_rd_ptr <= r_cmd_rd_ptr + 1'b1;
      end
      if (w_cmd_push && !w_cmd_pop) begin
        r_cmd_count <= r_cmd_count + 1'b1;
      end else if (w_cmd_pop && !w_cmd_push) begin
        r_cmd_count <= r_cmd_count - 1'b1;
      end

      if (w_res_push) begin
        r_res_mem[r_res_wr_ptr] <= res_data;
        r_res_wr_ptr            <= r_res_wr_ptr + 1'b1;
      end
      if (w_res_pop) begin
        r_res_rd_ptr <= r_res_rd_ptr + 1'b1;
      end
      if (w_res_push && !w_res_pop) begin
        r_res_count <= r_res_count + 1'b1;
      end else if (w_res_pop && !w_res_push) begin
        r_res_count <= r_res_count - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  logic [19:0] w_cmd_head;
  logic [15:0] w_res_head;
  assign w_cmd_head = w_cmd_empty ? 20'h0 : r_cmd_mem[r_cmd_rd_ptr];
  assign w_res_head = w_res_empty ? 16'h0 : r_res_mem[r_res_rd_ptr];

  assign op_a    = w_cmd_head[19:12];
  assign op_b    = w_cmd_head[11:4];
  assign op_code = w_cmd_head[3:0];

  always_comb begin
    data_out = 8'h00;
    case (address)
      4'h0:    data_out = r_stage_a;
      4'h1:    data_out = r_stage_b;
      4'h5:    data_out = w_res_head[7:0];
      4'h6:    data_out = w_res_head[15:8];
      4'h8:    data_out = {(r_state != IDLE), r_overflow,
                           3'(r_res_count), 3'(r_cmd_count)};
      default: data_out = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_accel_cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_accel_cmd_queue
//  Purpose  : Self-checking bench for accel_cmd_queue. Directed scenarios plus
//             randomized traffic, every cycle compared to a queue-based
//             reference model of the register/queue behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_accel_cmd_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  address;
  logic        data_write;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [3:0]  op_code;
  logic        op_valid;
  logic        op_ready;
  logic        res_valid;
  logic [15:0] res_data;

  accel_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_code    (op_code),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .res_valid  (res_valid),
    .res_data   (res_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------- reference model
  logic [7:0]  m_a = 8'h00;
  logic [7:0]  m_b = 8'h00;
  logic [19:0] m_cmd[$];
  logic [15:0] m_res[$];
  bit          m_ovf = 0;
  bit          m_offering = 0;   // a command is being presented to the math stage
  bit          m_inflight = 0;   // a command was accepted and its result is awaited
  logic [7:0]  m_fly_a = 8'h00;  // A operand of the accepted command

  // bench-side knobs for the math stage / reset
  bit          g_rst = 0;
  bit          g_rdy = 0;
  bit          g_rv = 0;
  bit          auto_rv = 0;
  logic [15:0] g_rdata = 16'h0;
  logic [7:0]  issued[$];

  function automatic logic [7:0] model_read(input logic [3:0] a);
    logic [15:0] h;
    h = (m_res.size() > 0) ? m_res[0] : 16'h0;
    case (a)
      4'h0:    return m_a;
      4'h1:    return m_b;
      4'h5:    return h[7:0];
      4'h6:    return h[15:8];
      4'h8:    return {(m_offering || m_inflight), m_ovf,
                       3'(m_res.size()), 3'(m_cmd.size())};
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_update(input bit r, input bit wr, input logic [3:0] a,
                              input logic [7:0] d, input bit rdy, input bit rv,
                              input logic [15:0] rdat);
    bit start, take, done, rpop;
    int ncmd, nres;
    if (r) begin
      m_a = 0; m_b = 0; m_ovf = 0; m_offering = 0; m_inflight = 0;
      m_cmd.delete(); m_res.delete();
      return;
    end
    ncmd  = m_cmd.size();
    nres  = m_res.size();
    start = !m_offering && !m_inflight && ncmd > 0 && nres < DEPTH;
    take  = m_offering && rdy;
    done  = m_inflight && rv;
    rpop  = wr && a == 4'h7 && nres > 0;
    if (take) begin
      m_fly_a = m_cmd[0][19:12];
      void'(m_cmd.pop_front());
    end
    if (wr && a == 4'h4) begin
      if (ncmd < DEPTH || take) m_cmd.push_back({m_a, m_b, d[3:0]});
      else m_ovf = 1;
    end
    if (rpop) void'(m_res.pop_front());
    if (done) m_res.push_back(rdat);
    if (wr && a == 4'h0) m_a = d;
    if (wr && a == 4'h1) m_b = d;
    if (wr && a == 4'h8 && d[6]) m_ovf = 0;
    m_inflight = take || (m_inflight && !rv);
    m_offering = start || (m_offering && !rdy);
  endtask

  // One clock: drive at negedge, compare outputs, advance model across posedge.
  task automatic step(input bit wr, input logic [3:0] a, input logic [7:0] d);
    bit          rv_now;
    logic [15:0] rd_now;
    logic [19:0] head;
    rv_now     = auto_rv ? m_inflight : g_rv;
    rd_now     = auto_rv ? {8'h5A, m_fly_a} : g_rdata;
    rst        = g_rst;
    data_write = wr;
    address    = a;
    data_in    = d;
    op_ready   = g_rdy;
    res_valid  = rv_now;
    res_data   = rd_now;
    #1;
    head = (m_cmd.size() > 0) ? m_cmd[0] : 20'h0;
    check("op_valid", op_valid, m_offering);
    check("op_a",     op_a,     head[19:12]);
    check("op_b",     op_b,     head[11:4]);
    check("op_code",  op_code,  head[3:0]);
    check("data_out", data_out, model_read(a));
    if (op_valid && g_rdy && !g_rst) issued.push_back(op_a);
    model_update(g_rst, wr, a, d, g_rdy, rv_now, rd_now);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'hF, 8'h00);
  endtask

  task automatic peek(input string tag, input logic [3:0] a, input logic [7:0] exp);
    data_write = 0;
    address    = a;
    #1;
    check(tag, data_out, exp);
  endtask

  task automatic do_reset();
    g_rst = 1; step(0, 4'hF, 8'h00); g_rst = 0;
    g_rdy = 0; g_rv = 0; auto_rv = 0;
  endtask

  initial begin
    rst = 1; data_write = 0; address = 0; data_in = 0;
    op_ready = 0; res_valid = 0; res_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    peek("rst_status", 4'h8, 8'h00);
    check("rst_op_valid", op_valid, 0);

    // single operation
    do_reset();
    g_rdy = 1;
    step(1, 4'h0, 8'h12); step(1, 4'h1, 8'h34); step(1, 4'h4, 8'h00);
    g_rdy = 1; idle(3);
    g_rv = 1; g_rdata = 16'h0046; idle(1); g_rv = 0;
    peek("single_lo", 4'h5, 8'h46);
    peek("single_hi", 4'h6, 8'h00);
    peek("single_st", 4'h8, 8'h08);
    step(1, 4'h7, 8'h00);
    peek("single_pop", 4'h8, 8'h00);

    // overflow
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 4'h4, 8'(i));
    peek("ovf_status", 4'h8, 8'hC4);
    step(1, 4'h8, 8'h40);
    peek("ovf_clear", 4'h8, 8'h84);

    // result backpressure
    do_reset();
    g_rdy = 1; auto_rv = 1;
    for (int i = 0; i < 4; i++) step(1, 4'h4, 8'(i));
    idle(20);
    peek("bp_full", 4'h8, 8'h20);
    step(1, 4'h4, 8'h09);
    idle(3);
    check("bp_hold", op_valid, 0);
    step(1, 4'h7, 8'h00);
    idle(1);
    #1 check("bp_rise", op_valid, 1);

    // ordering
    do_reset();
    g_rdy = 1; auto_rv = 1;
    issued.delete();
    for (int i = 1; i <= 4; i++) begin
      step(1, 4'h0, 8'(i)); step(1, 4'h4, 8'h3);
    end
    idle(20);
    check("ord_count", issued.size(), 4);
    for (int i = 0; i < 4 && i < issued.size(); i++) check("ord_issue", issued[i], i + 1);
    for (int i = 1; i <= 4; i++) begin
      peek("ord_res", 4'h5, 8'(i));
      step(1, 4'h7, 8'h00);
    end

    // reset while waiting for a result
    do_reset();
    g_rdy = 1;
    step(1, 4'h0, 8'h77); step(1, 4'h4, 8'h1);
    idle(3);
    check("rw_busy", data_out, 8'h0); // address 0xF reads zero
    do_reset();
    g_rv = 1; g_rdata = 16'hBEEF; idle(1); g_rv = 0;
    peek("rw_status", 4'h8, 8'h00);
    peek("rw_lo", 4'h5, 8'h00);

    // simultaneous events
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 4'h4, 8'(i));
    g_rdy = 1; step(1, 4'h4, 8'h9); g_rdy = 0;
    peek("sim_push", 4'h8, 8'h84);
    g_rv = 1; g_rdata = 16'h1111; idle(1); g_rv = 0;
    idle(1);
    g_rdy = 1; idle(1); g_rdy = 0;
    g_rv = 1; g_rdata = 16'h2222; step(1, 4'h7, 8'h00); g_rv = 0;
    address = 4'h8; #1;
    check("sim_rescnt", data_out[5:3], 1);
    peek("sim_head", 4'h5, 8'h22);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      logic [3:0] a;
      case ($urandom_range(0, 7))
        0: a = 4'h0;
        1: a = 4'h1;
        2, 3: a = 4'h4;
        4: a = 4'h7;
        5: a = 4'h8;
        6: a = 4'h5;
        default: a = 4'($urandom);
      endcase
      g_rst   = ($urandom_range(0, 63) == 0);
      g_rdy   = ($urandom_range(0, 2) != 0);
      g_rv    = ($urandom_range(0, 3) == 0);
      g_rdata = 16'($urandom);
      step($urandom_range(0, 1) == 1, a, 8'($urandom));
    end
    g_rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
